// File: rtl/bsg_level_shift_en_seq.sv
// Isolation-enable sequencer for a v0->v1 level shifter with a one-entry output register.
// Define BSG_LEVEL_SHIFT_PWR_GOOD_SYNC_EN to pass pwr_good_i through a 2-flop synchronizer.
module bsg_level_shift_en_seq #(
  parameter int width_p         = 16,
  parameter int settle_cycles_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               pwr_good_i,
  input  logic               iso_req_i,
  input  logic [width_p-1:0] v0_data_i,
  input  logic               v0_valid_i,
  output logic               v0_ready_o,
  output logic               v1_en_o,
  output logic [width_p-1:0] v1_data_o,
  output logic               v1_valid_o,
  input  logic               v1_ready_i,
  output logic               active_o
);

  typedef enum logic [1:0] {ISOLATED, SETTLE, ACTIVE, DRAIN} state_e;

  state_e     state_r, state_n;
  logic [7:0] cnt_r, cnt_n;
  logic       pg;
  logic       flush;
  logic       load;

`ifdef BSG_LEVEL_SHIFT_PWR_GOOD_SYNC_EN
  logic [1:0] pg_sync_r;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) pg_sync_r <= '0;
    else         pg_sync_r <= {pg_sync_r[0], pwr_good_i};
  end
  assign pg = pg_sync_r[1];
`else
  assign pg = pwr_good_i;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= ISOLATED;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state_r;
    cnt_n      = cnt_r;
    v1_en_o    = 1'b0;
    v0_ready_o = 1'b0;
    flush      = 1'b0;
    case (state_r)
      ISOLATED: begin
        if (pg && !iso_req_i) begin
          state_n = SETTLE;
          cnt_n   = 8'(settle_cycles_p - 1);
        end
      end
      SETTLE: begin
        // loss of power or a new isolate request wins over an expiring count
        if (!pg || iso_req_i)  state_n = ISOLATED;
        else if (cnt_r == '0)  state_n = ACTIVE;
        else                   cnt_n   = cnt_r - 8'd1;
      end
      ACTIVE: begin
        v1_en_o = 1'b1;
        if (!pg) begin
          flush   = 1'b1;
          state_n = ISOLATED;
        end else begin
          v0_ready_o = !iso_req_i && (!v1_valid_o || v1_ready_i);
          if (iso_req_i) state_n = DRAIN;
        end
      end
      DRAIN: begin
        v1_en_o = 1'b1;
        if (!pg) begin
          flush   = 1'b1;
          state_n = ISOLATED;
        end else if (!v1_valid_o || v1_ready_i) begin
          state_n = ISOLATED;
        end
      end
      default: state_n = ISOLATED;
    endcase
  end

  assign load     = v0_valid_i && v0_ready_o;
  assign active_o = (state_r == ACTIVE);

  // Data is zeroed whenever the slot empties so v1_data_o reads 0 while invalid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      v1_valid_o <= 1'b0;
      v1_data_o  <= '0;
    end else if (flush) begin
      v1_valid_o <= 1'b0;
      v1_data_o  <= '0;
    end else if (load) begin
      v1_valid_o <= 1'b1;
      v1_data_o  <= v0_data_i & {width_p{v1_en_o}};
    end else if (v1_valid_o && v1_ready_i) begin
      v1_valid_o <= 1'b0;
      v1_data_o  <= '0;
    end
  end

endmodule

// File: tb/tb_bsg_level_shift_en_seq.sv
// Bench for bsg_level_shift_en_seq: vector table, corner sequences, random run vs. reference model.
module tb_bsg_level_shift_en_seq;

`ifdef BSG_LEVEL_SHIFT_PWR_GOOD_SYNC_EN
  localparam int PG_LAT = 2;
`else
  localparam int PG_LAT = 0;
`endif
  localparam int SETTLE = 4;

  logic        clk, rst, pwr, iso, v0v, v1r;
  logic [15:0] v0d;
  logic        v0_rdy, en, v1v, act;
  logic [15:0] v1d;
  int          errs, checks;

  bsg_level_shift_en_seq #(.width_p(16), .settle_cycles_p(SETTLE)) dut (
    .clk_i(clk), .reset_i(rst), .pwr_good_i(pwr), .iso_req_i(iso),
    .v0_data_i(v0d), .v0_valid_i(v0v), .v0_ready_o(v0_rdy),
    .v1_en_o(en), .v1_data_o(v1d), .v1_valid_o(v1v), .v1_ready_i(v1r),
    .active_o(act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [15:0] actual, input logic [15:0] exp);
    checks++;
    if (actual !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, actual, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic e_en, input logic e_act,
                         input logic e_rdy, input logic e_vld, input logic [15:0] e_d);
    chk({tag, ".en"},   16'(en),     16'(e_en));
    chk({tag, ".act"},  16'(act),    16'(e_act));
    chk({tag, ".rdy"},  16'(v0_rdy), 16'(e_rdy));
    chk({tag, ".vld"},  16'(v1v),    16'(e_vld));
    chk({tag, ".data"}, v1d,         e_d);
  endtask

  // Reset held for two edges, released 1 time unit after a rising edge: that cycle is cycle 0.
  task automatic do_reset();
    rst = 1'b1; pwr = 1'b0; iso = 1'b0; v0v = 1'b0; v0d = '0; v1r = 1'b0;
    step();
    chk_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    step();
    rst = 1'b0;
  endtask

  // Cycle index (edges since release) at which active_o first reads 1.
  task automatic measure_up(input string name, input int exp);
    int n;
    n = 0;
    pwr = 1'b1; iso = 1'b0;
    #1;
    while (!act && n < 40) begin
      step();
      n++;
    end
    chk(name, 16'(n), 16'(exp));
    chk({name, ".en"}, 16'(en), 16'h1);
  endtask

  typedef struct {
    logic pwr, iso, v0v; logic [15:0] v0d; logic v1r;
    logic en, act, rdy, vld; logic [15:0] d;
  } vec_t;
  vec_t tbl[12];

  // reference model state
  int          m_st;     // 0 isolated, 1 settling, 2 active, 3 draining
  int          m_left;
  logic        m_vld;
  logic [15:0] m_d;
  logic [1:0]  m_pd;

  initial begin
    errs = 0; checks = 0;
    rst = 1'b1; pwr = 1'b0; iso = 1'b0; v0v = 1'b0; v0d = '0; v1r = 1'b0;

    // power-up latency from reset (5 cycles, 7 with the synchronizer)
    do_reset();
    measure_up("powerup_latency", 5 + PG_LAT);

`ifndef BSG_LEVEL_SHIFT_PWR_GOOD_SYNC_EN
    // pwr iso v0v data v1r | en act rdy vld data
    tbl[0]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0000};
    tbl[1]  = tbl[0]; tbl[2] = tbl[0]; tbl[3] = tbl[0]; tbl[4] = tbl[0];
    tbl[5]  = '{1'b1,1'b0,1'b1,16'hA5C3,1'b1, 1'b1,1'b1,1'b1,1'b0,16'h0000};
    tbl[6]  = '{1'b1,1'b0,1'b1,16'h1234,1'b1, 1'b1,1'b1,1'b1,1'b1,16'hA5C3};
    tbl[7]  = '{1'b1,1'b0,1'b1,16'h0F0F,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h1234};
    tbl[8]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b1,1'b0,1'b1,16'h1234};
    tbl[9]  = '{1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b1,1'b0,1'b0,1'b1,16'h1234};
    tbl[10] = '{1'b1,1'b1,1'b0,16'h0000,1'b1, 1'b1,1'b0,1'b0,1'b1,16'h1234};
    tbl[11] = '{1'b1,1'b1,1'b0,16'h0000,1'b0, 1'b0,1'b0,1'b0,1'b0,16'h0000};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      pwr = tbl[i].pwr; iso = tbl[i].iso; v0v = tbl[i].v0v; v0d = tbl[i].v0d; v1r = tbl[i].v1r;
      #1;
      chk_all($sformatf("vec%0d", i), tbl[i].en, tbl[i].act, tbl[i].rdy, tbl[i].vld, tbl[i].d);
      step();
    end

    // power loss while holding a beat
    do_reset();
    measure_up("pl_up", 5);
    v0v = 1'b1; v0d = 16'hBEEF; v1r = 1'b0;
    step();
    v0v = 1'b0;
    #1;
    chk("pl_held_vld", 16'(v1v), 16'h1);
    chk("pl_held_data", v1d, 16'hBEEF);
    pwr = 1'b0;
    step();
    chk_all("pl_after", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // asynchronous reset mid-transfer
    do_reset();
    measure_up("rx_up", 5);
    v0v = 1'b1; v0d = 16'h5A5A; v1r = 1'b0;
    step();
    v0v = 1'b0;
    #2;
    chk("rx_held_vld", 16'(v1v), 16'h1);
    rst = 1'b1;
    #1;
    chk_all("rx_async", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // reset pulsed in SETTLE with the counter at 2, then a full settle again
    step();
    rst = 1'b0;
    pwr = 1'b1; iso = 1'b0;
    step(); step();
    #2;
    rst = 1'b1;
    #1;
    chk_all("rs_async", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step();
    rst = 1'b0;
    measure_up("rs_resettle", 5);
`endif

    // random run against the reference model
    do_reset();
    m_st = 0; m_left = 0; m_vld = 1'b0; m_d = '0; m_pd = '0;
    for (int c = 0; c < 800; c++) begin
      logic pg_m, e_rdy;
      pwr = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 11) == 0) iso = ~iso;
      v0v = $urandom_range(0, 1);
      v0d = 16'($urandom);
      v1r = ($urandom_range(0, 3) != 0);
      #1;
`ifdef BSG_LEVEL_SHIFT_PWR_GOOD_SYNC_EN
      pg_m = m_pd[1];
`else
      pg_m = pwr;
`endif
      e_rdy = (m_st == 2) && pg_m && !iso && (!m_vld || v1r);
      chk_all($sformatf("rnd%0d", c), (m_st == 2 || m_st == 3), (m_st == 2), e_rdy,
              m_vld, m_vld ? m_d : 16'h0000);
      chk($sformatf("rnd%0d.en_vld", c), 16'(!en && v1v), 16'h0);
      case (m_st)
        0: if (pg_m && !iso) begin m_st = 1; m_left = SETTLE - 1; end
        1: if (!pg_m || iso) m_st = 0;
           else if (m_left == 0) m_st = 2;
           else m_left--;
        2: if (!pg_m) begin
             m_st = 0; m_vld = 1'b0;
           end else begin
             if (e_rdy && v0v) begin m_vld = 1'b1; m_d = v0d; end
             else if (m_vld && v1r) m_vld = 1'b0;
             if (iso) m_st = 3;
           end
        default: if (!pg_m) begin m_st = 0; m_vld = 1'b0; end
                 else if (!m_vld || v1r) begin m_st = 0; m_vld = 1'b0; end
      endcase
      m_pd = {m_pd[0], pwr};
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
